// File: rtl/decoder_nx2n_pulse_if.sv
// Request channel of decoder_nx2n_pulse: select code and pulse length over valid/ready.
//   master : requester (drives in_valid, in_sel, in_len; observes in_ready)
//   slave  : decoder   (observes in_valid, in_sel, in_len; drives in_ready)
interface decoder_nx2n_pulse_if #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LEN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic [LEN_W-1:0] in_len;

    modport master (output in_valid, output in_sel, output in_len, input in_ready);
    modport slave  (input in_valid, input in_sel, input in_len, output in_ready);
endinterface

// File: rtl/decoder_nx2n_pulse.sv
// N-to-2^N one-hot decoder with registered, timed pulse outputs.
// A request (select, length) is accepted over a valid/ready handshake; the selected
// line is driven high for max(len,1) cycles, followed by a one-cycle done strobe.
// Optional macro DECODER_PULSE_GAP_EN: after the pulse, hold off for an equal-length
// all-zero gap (50% duty cycle) and strobe done at the end of the gap instead.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   en         : block enable; low aborts an active pulse/gap without done
//   req        : request channel (in_valid, in_ready, in_sel, in_len)
//   out_y      : registered one-hot / all-zero line outputs
//   busy       : high whenever the FSM is not idle
//   done       : one-cycle completion strobe
module decoder_nx2n_pulse #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    decoder_nx2n_pulse_if.slave      req,
    output logic [(2**SEL_W)-1:0]    out_y,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned OUT_N = 2 ** SEL_W;

`ifdef DECODER_PULSE_GAP_EN
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, PULSE} state_t;
`endif

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic [OUT_N-1:0]   out_nxt;
    logic               done_nxt;
`ifdef DECODER_PULSE_GAP_EN
    logic [LEN_W-1:0]   len_q, len_nxt;   // pulse length minus one, reused as gap length
`endif

    // Handshake and status derive from the state register only.
    assign req.in_ready = en && (state == IDLE);
    assign busy         = (state != IDLE);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sel_q <= '0;
            out_y <= '0;
            done  <= 1'b0;
`ifdef DECODER_PULSE_GAP_EN
            len_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel_q <= sel_nxt;
            out_y <= out_nxt;
            done  <= done_nxt;
`ifdef DECODER_PULSE_GAP_EN
            len_q <= len_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        out_nxt   = '0;
        done_nxt  = 1'b0;
`ifdef DECODER_PULSE_GAP_EN
        len_nxt   = len_q;
`endif
        case (state)
            IDLE: begin
                if (en && req.in_valid) begin
                    sel_nxt   = req.in_sel;
                    // Zero length maps to one cycle, so cnt never underflows.
                    cnt_nxt   = (req.in_len == '0) ? '0 : req.in_len - LEN_W'(1);
                    out_nxt   = OUT_N'(1) << req.in_sel;
                    state_nxt = PULSE;
`ifdef DECODER_PULSE_GAP_EN
                    len_nxt   = (req.in_len == '0) ? '0 : req.in_len - LEN_W'(1);
`endif
                end
            end
            PULSE: begin
                if (!en) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt   = cnt - LEN_W'(1);
                    out_nxt   = OUT_N'(1) << sel_q;
                end else begin
`ifdef DECODER_PULSE_GAP_EN
                    cnt_nxt   = len_q;
                    state_nxt = GAP;
`else
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef DECODER_PULSE_GAP_EN
            GAP: begin
                if (!en) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt   = cnt - LEN_W'(1);
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
